// File: rtl/mem_port_pkg.sv
// Shared definitions for the unified memory port initiator: access sizes,
// controller states and the alignment rule.
package mem_port_pkg;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_F = 2'd1,
    ACC_D = 2'd2,
    ERR   = 2'd3
  } state_t;

  // A size is legal only at an address that is a multiple of its width.
  function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_W:    ok = (addr_lo == 2'b00);
      SZ_H:    ok = !addr_lo[0];
      SZ_B:    ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter; req/gnt bit 0 is fetch, bit 1 is load/store.
module mem_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_fetch;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt = '0;
    if (en) begin
      gnt[0] = req[0] & (!req[1] | !last_fetch);
      gnt[1] = req[1] & (!req[0] |  last_fetch);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_fetch <= 1'b1;
    end else if (|gnt) begin
      last_fetch <= gnt[0];
    end
  end

endmodule

// File: rtl/mem_port_master.sv
// Initiator of the shared instruction/data memory port: arbitrates fetch and
// load/store, issues one registered memory command and returns the result.
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_phase,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t     state;
  logic       idle;
  logic [1:0] gnt;
  logic       ls_legal;

  assign idle     = (state == IDLE);
  assign if_ready = idle;
  assign ls_ready = idle;
  assign ls_legal = align_ok(ls_size, ls_addr[1:0]);

  mem_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle),
    .req   ({ls_req, if_req}),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_phase  <= 1'b1;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_size   <= SZ_W;
      mem_signed <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      if_inst    <= '0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      ls_err     <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      ls_rvalid <= 1'b0;
      if (state == IDLE) begin
        if (gnt[0]) begin
          state     <= ACC_F;
          mem_phase <= 1'b1;
          mem_addr  <= if_addr & ~ADDR_W'(3);
        end else if (gnt[1]) begin
          // Illegal requests skip the memory entirely; command flops stay idle.
          if (ls_legal) begin
            state      <= ACC_D;
            mem_phase  <= 1'b0;
            mem_read   <= !ls_we;
            mem_write  <= ls_we;
            mem_size   <= ls_size;
            mem_signed <= ls_signed;
            mem_addr   <= ls_addr;
            mem_wdata  <= ls_wdata;
          end else begin
            state <= ERR;
          end
        end
      end else begin
        state      <= IDLE;
        mem_phase  <= 1'b1;
        mem_read   <= 1'b0;
        mem_write  <= 1'b0;
        mem_size   <= SZ_W;
        mem_signed <= 1'b0;
        mem_addr   <= '0;
        mem_wdata  <= '0;
        if (state == ACC_F) begin
          if_valid <= 1'b1;
          if_inst  <= mem_rdata;
        end else if (state == ACC_D) begin
          ls_rvalid <= 1'b1;
          ls_err    <= 1'b0;
          ls_rdata  <= mem_write ? '0 : mem_rdata;
        end else begin
          ls_rvalid <= 1'b1;
          ls_err    <= 1'b1;
          ls_rdata  <= '0;
        end
      end
    end
  end

endmodule
